// File: rtl/add_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract sequencer built around one shared 16-bit carry-lookahead
// adder. Slices are processed LSB first with a registered carry, and the block produces N/Z/C/V flags.

module cla_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] sum_o,
  output logic        gg_o,
  output logic        pg_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic        grp_c;
  logic        bit_c;

  // Four 4-bit lookahead groups; group carries chain through group generate/propagate.
  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    g     = a_i & b_i;
    p     = a_i ^ b_i;
    grp_g = '0;
    grp_p = '0;
    sum_o = '0;
    grp_c = c_i;
    bit_c = c_i;
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
      bit_c    = grp_c;
      for (int j = 0; j < 4; j++) begin
        sum_o[4*k+j] = p[4*k+j] ^ bit_c;
        bit_c        = g[4*k+j] | (p[4*k+j] & bit_c);
      end
      grp_c = grp_g[k] | (grp_p[k] & grp_c);
    end
    gg_o = grp_g[3]
         | (grp_p[3] & grp_g[2])
         | (grp_p[3] & grp_p[2] & grp_g[1])
         | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    pg_o = &grp_p;
  end

endmodule

module add_seq_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / 16;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [15:0] slice_sum;
  logic        slice_gg;
  logic        slice_pg;
  logic        carry_nxt;
  logic        accept;

  cla_16bit u_cla (
    .a_i   (a_q[16*idx_q +: 16]),
    .b_i   (b_q[16*idx_q +: 16]),
    .c_i   (carry_q),
    .sum_o (slice_sum),
    .gg_o  (slice_gg),
    .pg_o  (slice_pg)
  );

  assign carry_nxt = slice_gg | (slice_pg & carry_q);

  // DONE accepts a new op in the same cycle the result is taken, so back-to-back ops need no bubble.
  assign in_ready = reset & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_RUN: begin
        result_d[16*idx_q +: 16] = slice_sum;
        carry_d = carry_nxt;
        zacc_d  = zacc_q & (slice_sum == 16'h0);
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          cout_d  = carry_nxt;
          neg_d   = slice_sum[15];
          zero_d  = zacc_q & (slice_sum == 16'h0);
          // Carry into the MSB is a^b'^sum there; xor with the carry out gives signed overflow.
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[15] ^ carry_nxt;
        end
      end
      S_DONE: begin
        if (out_ready && !in_valid) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Subtraction is folded in here: B is inverted and the +1 enters as the initial carry.
    if (accept) begin
      state_d = S_RUN;
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = sub;
      idx_d   = '0;
      zacc_d  = 1'b1;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign negative  = neg_q;
  assign zero      = zero_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: a transaction-level model checked every cycle,
// plus directed vectors with hand-computed results.

module tb_add_seq_ctrl;

  localparam int WIDTH  = 64;
  localparam int NSLICE = WIDTH / 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  always #5 clk = ~clk;

  add_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted op becomes visible NSLICE edges later.
  bit               m_busy  = 1'b0;
  bit               m_valid = 1'b0;
  int               m_cnt   = 0;
  logic [WIDTH-1:0] m_res   = '0;
  logic             m_n = 1'b0, m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;
  logic [WIDTH-1:0] p_res   = '0;
  logic             p_n = 1'b0, p_z = 1'b0, p_c = 1'b0, p_v = 1'b0;

  function automatic bit m_in_ready();
    return reset && !m_busy && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin : model
    bit               acc;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    if (!reset) begin
      m_busy = 0; m_valid = 0; m_cnt = 0;
      m_res = '0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    end else begin
      acc = in_valid && m_in_ready();
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_valid = 1;
          m_res = p_res; m_n = p_n; m_z = p_z; m_c = p_c; m_v = p_v;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (acc) begin
        bb    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sub);
        p_res = full[WIDTH-1:0];
        p_c   = full[WIDTH];
        p_n   = p_res[WIDTH-1];
        p_z   = (p_res == '0);
        p_v   = (a[WIDTH-1] == bb[WIDTH-1]) && (p_res[WIDTH-1] != a[WIDTH-1]);
        m_busy = 1; m_cnt = NSLICE;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("mdl_out_valid", out_valid, m_valid);
      check("mdl_in_ready", in_ready, m_in_ready());
      if (!m_busy) check("mdl_result", result, m_res);
      check("mdl_negative", negative, m_n);
      check("mdl_zero", zero, m_z);
      check("mdl_carry", carry_out, m_c);
      check("mdl_overflow", overflow, m_v);
    end
  end

  // Called just after a posedge; returns just after the accept edge with junk on the operands.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic ts);
    bit got = 0;
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    sub = 1'($urandom);
    if (!got) check("accept_timeout", 0, 1);
  endtask

  // Counts edges after the accept edge until out_valid is seen; returns at that negedge.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic handoff();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic ts, input logic [WIDTH-1:0] er,
                        input logic en, input logic ez, input logic ec, input logic ev);
    int lat;
    send(ta, tb, ts);
    wait_result(lat);
    check({name, "_latency"}, lat, NSLICE);
    check({name, "_result"}, result, er);
    check({name, "_N"}, negative, en);
    check({name, "_Z"}, zero, ez);
    check({name, "_C"}, carry_out, ec);
    check({name, "_V"}, overflow, ev);
    handoff();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_result", result, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 0, 1, 1, 0);
    run_op("slice_carry", 64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0,
           64'h0000_0001_0000_0000, 0, 0, 0, 0);
    run_op("sub_5_7", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0);
    run_op("sub_7_5", 64'd7, 64'd5, 1'b1, 64'h2, 0, 0, 1, 0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1, 0, 0, 1);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1);

    // Backpressure, then a back-to-back accept in the handoff cycle.
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    wait_result(lat);
    check("bp_latency", lat, NSLICE);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, 64'h2345_6789_ABCD_F001);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 64'h0; b = 64'h1; sub = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    wait_result(lat);
    check("b2b_latency", lat, NSLICE);
    check("b2b_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b2b_N", negative, 1);
    check("b2b_C", carry_out, 0);
    check("b2b_V", overflow, 0);
    handoff();

    // Reset during the second RUN cycle abandons the op.
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", {negative, zero, carry_out, overflow}, 0);
    @(posedge clk); #1;
    run_op("after_rst", 64'd3, 64'd4, 1'b0, 64'd7, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
